mem_port_arbiter: RTL and testbench

//  Shares the single-port program/data memory between the CPU core and a program loader/debug port.

---
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port program/data memory between the CPU core and a
// program loader / debug port. Both sides use a level req/gnt handshake.
// Grants are registered, and ownership alternates on ties. When the other
// side is waiting, one owner may hold the port for at most MAX_HOLD
// consecutive cycles.
//
// Parameters
//   DATA_WIDTH  memory data width
//   ADDR_WIDTH  memory address width
//   MAX_HOLD    max consecutive owned cycles while the other side waits (>=2)
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   cpu_req/wr/addr/wdata        CPU request side
//   cpu_gnt, cpu_stall           CPU owns the port / CPU is waiting
//   cpu_rvalid, cpu_rdata        read return to the CPU
//   ld_req/wr/addr/wdata         loader request side
//   ld_gnt                       loader owns the port
//   ld_rvalid, ld_rdata          read return to the loader
//   mem_rd/wr/addr/wdata         memory strobes and address/data
//   mem_rdata                    memory read data, valid 1 cycle after mem_rd
//
// Optional feature (macro ARB_STATS_EN):
//   conflict_cnt [15:0]  cycles where both sides request and one is granted
//   forced_cnt   [7:0]   number of MAX_HOLD forced hand-overs
//   Both counters saturate at all-ones. Arbitration is the same with or
//   without the macro.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_HOLD   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_wr,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ld_req,
    input  logic                  ld_wr,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_gnt,
    output logic                  ld_rvalid,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]           conflict_cnt,
    output logic [7:0]            forced_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_LD} state_t;
    typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_LD} rd_owner_t;

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    rd_owner_t         rd_owner;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last_was_cpu;   // 0 = loader was served last
    logic              cpu_forced;     // CPU has used up its hold budget
    logic              ld_forced;      // loader has used up its hold budget

    // A forced hand-over happens only while the owner still requests and the
    // other side is waiting. A saturated counter with no contender does nothing.
    assign cpu_forced = (state == OWN_CPU) && cpu_req && ld_req && (hold_cnt == HOLD_LAST);
    assign ld_forced  = (state == OWN_LD)  && ld_req && cpu_req && (hold_cnt == HOLD_LAST);

    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Arbitration FSM. The grant outputs are registered together with the state.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cpu_gnt      <= 1'b0;
            ld_gnt       <= 1'b0;
            hold_cnt     <= '0;
            last_was_cpu <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (cpu_req && (!ld_req || !last_was_cpu)) begin
                        state        <= OWN_CPU;
                        cpu_gnt      <= 1'b1;
                        last_was_cpu <= 1'b1;
                    end else if (ld_req) begin
                        state        <= OWN_LD;
                        ld_gnt       <= 1'b1;
                        last_was_cpu <= 1'b0;
                    end
                end
                OWN_CPU: begin
                    if (!cpu_req) begin
                        state    <= IDLE;
                        cpu_gnt  <= 1'b0;
                        hold_cnt <= '0;
                    end else if (cpu_forced) begin
                        state        <= OWN_LD;
                        cpu_gnt      <= 1'b0;
                        ld_gnt       <= 1'b1;
                        hold_cnt     <= '0;
                        last_was_cpu <= 1'b0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                OWN_LD: begin
                    if (!ld_req) begin
                        state    <= IDLE;
                        ld_gnt   <= 1'b0;
                        hold_cnt <= '0;
                    end else if (ld_forced) begin
                        state        <= OWN_CPU;
                        ld_gnt       <= 1'b0;
                        cpu_gnt      <= 1'b1;
                        hold_cnt     <= '0;
                        last_was_cpu <= 1'b1;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cpu_gnt  <= 1'b0;
                    ld_gnt   <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    // Memory drive comes combinationally from the current owner.
    // NOTE: every output gets a default first, so no path leaves a signal
    // unassigned and no latch is inferred.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_rd    = ~cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ld_gnt) begin
            mem_rd    = ~ld_wr;
            mem_wr    = ld_wr;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    // Remember who issued the read so the data returns to that side, even when
    // ownership changes on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_owner <= RD_NONE;
        end else if (mem_rd) begin
            rd_owner <= cpu_gnt ? RD_CPU : RD_LD;
        end else begin
            rd_owner <= RD_NONE;
        end
    end

    assign cpu_rvalid = (rd_owner == RD_CPU);
    assign ld_rvalid  = (rd_owner == RD_LD);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ld_rdata   = ld_rvalid  ? mem_rdata : '0;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
            forced_cnt   <= '0;
        end else begin
            if (cpu_req && ld_req && (cpu_gnt ^ ld_gnt) && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
            if ((cpu_forced || ld_forced) && (forced_cnt != 8'hFF))
                forced_cnt <= forced_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (DATA_WIDTH=8, ADDR_WIDTH=5, MAX_HOLD=8).
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req, cpu_wr, ld_req, ld_wr;
    logic [4:0] cpu_addr, ld_addr;
    logic [7:0] cpu_wdata, ld_wdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid, ld_gnt, ld_rvalid;
    logic [7:0] cpu_rdata, ld_rdata;
    logic       mem_rd, mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
`ifdef ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [7:0]  forced_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:31];

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
        , .conflict_cnt(conflict_cnt), .forced_cnt(forced_cnt)
`endif
    );

    // Single-port memory model with one cycle of read latency.
    initial for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b1; ld_req = 1'b1;
        cpu_wr = 1'b0; ld_wr = 1'b0; cpu_addr = '0; ld_addr = '0; cpu_wdata = '0; ld_wdata = '0;
        tick(); tick();
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got %0b want 0", cpu_gnt); end
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL reset_ld_gnt got %0b want 0", ld_gnt); end
        checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_strobes got %0b%0b want 00", mem_rd, mem_wr); end
        checks++; if (mem_addr !== 5'd0 || mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_mem_bus got %0h/%0h want 0/0", mem_addr, mem_wdata); end
        checks++; if (cpu_rvalid !== 1'b0 || ld_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b%0b want 00", cpu_rvalid, ld_rvalid); end
        rst = 1'b0;
        tick();
        cpu_req = 1'b0; ld_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL tie_first_cpu_gnt got %0b want 1", cpu_gnt); end
        checks++; if (ld_gnt !== 1'b0) begin errors++; $display("FAIL tie_first_ld_gnt got %0b want 0", ld_gnt); end
        tick(); tick();
    endtask

    task automatic test_write_read();
        ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 5'd5; ld_wdata = 8'hA3;
        tick();
        ld_req = 1'b0;  // keep ld_wr so the write completes in this owned cycle
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b1) begin errors++; $display("FAIL wr_ld_gnt got %0b want 1", ld_gnt); end
        checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL wr_strobe got wr=%0b rd=%0b want wr=1 rd=0", mem_wr, mem_rd); end
        checks++; if (mem_addr !== 5'd5 || mem_wdata !== 8'hA3) begin errors++; $display("FAIL wr_bus got %0h/%0h want 5/a3", mem_addr, mem_wdata); end
        tick();
        ld_wr = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd5;
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL wr_pulse_end got gnt=%0b wr=%0b want 0/0", ld_gnt, mem_wr); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 5'd5) begin errors++; $display("FAIL rd_issue got gnt=%0b rd=%0b addr=%0h want 1/1/5", cpu_gnt, mem_rd, mem_addr); end
        tick();
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA3) begin errors++; $display("FAIL rd_return got v=%0b d=%0h want 1/a3", cpu_rvalid, cpu_rdata); end
        checks++; if (ld_rvalid !== 1'b0 || ld_rdata !== 8'h00) begin errors++; $display("FAIL rd_other_side got v=%0b d=%0h want 0/00", ld_rvalid, ld_rdata); end
        tick();
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse got %0b want 0", cpu_rvalid); end
    endtask

    // Loader was not served last here, so it wins the opening tie.
    task automatic test_alternate();
        logic exp_ld;
        int stall_cycles;
        stall_cycles = 0;
        tick();
        cpu_req = 1'b1; ld_req = 1'b1; cpu_wr = 1'b0; ld_wr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            @(negedge clk);
            exp_ld = ((i / 8) % 2) == 0;
            if (cpu_stall === 1'b1 && i < 16) stall_cycles++;
            checks++;
            if (ld_gnt !== exp_ld || cpu_gnt !== !exp_ld || cpu_stall !== exp_ld) begin
                errors++;
                $display("FAIL alt_cycle_%0d got ld=%0b cpu=%0b stall=%0b want ld=%0b cpu=%0b stall=%0b",
                         i, ld_gnt, cpu_gnt, cpu_stall, exp_ld, !exp_ld, exp_ld);
            end
        end
        checks++; if (stall_cycles != 8) begin errors++; $display("FAIL alt_stall_count got %0d want 8", stall_cycles); end
        cpu_req = 1'b0; ld_req = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b0 || ld_gnt !== 1'b0) begin errors++; $display("FAIL alt_release got %0b%0b want 00", cpu_gnt, ld_gnt); end
    endtask

    // CPU reads in its last owned cycle, then the loader takes the port.
    // The loader then has a read in flight when reset arrives.
    task automatic test_read_switch_and_reset();
        tick();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd5;
        tick();
        ld_req = 1'b1; ld_wr = 1'b0; ld_addr = 5'd0;
        repeat (7) tick();
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 5'd5) begin errors++; $display("FAIL last_cycle_read got gnt=%0b rd=%0b addr=%0h want 1/1/5", cpu_gnt, mem_rd, mem_addr); end
        tick();
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b1 || cpu_gnt !== 1'b0 || cpu_stall !== 1'b1) begin errors++; $display("FAIL forced_switch got ld=%0b cpu=%0b stall=%0b want 1/0/1", ld_gnt, cpu_gnt, cpu_stall); end
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hA3) begin errors++; $display("FAIL switch_rd_return got v=%0b d=%0h want 1/a3", cpu_rvalid, cpu_rdata); end
        checks++; if (ld_rvalid !== 1'b0) begin errors++; $display("FAIL switch_ld_rvalid got %0b want 0", ld_rvalid); end
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL ld_read_pending got %0b want 1", mem_rd); end
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL midreset_gnt got ld=%0b cpu=%0b want 0/0", ld_gnt, cpu_gnt); end
        checks++; if (ld_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL midreset_rvalid got ld=%0b cpu=%0b want 0/0", ld_rvalid, cpu_rvalid); end
        checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL midreset_strobes got %0b%0b want 00", mem_rd, mem_wr); end
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || ld_gnt !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL postreset_tie got cpu=%0b ld=%0b stall=%0b want 1/0/0", cpu_gnt, ld_gnt, cpu_stall); end
        // The CPU drops its request while the loader waits: one IDLE cycle follows.
        cpu_req = 1'b0; ld_addr = 5'd5;
        tick();
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b0 || ld_gnt !== 1'b0) begin errors++; $display("FAIL drop_idle_gap got cpu=%0b ld=%0b want 0/0", cpu_gnt, ld_gnt); end
        tick();
        ld_req = 1'b0;
        @(negedge clk);
        checks++; if (ld_gnt !== 1'b1 || mem_rd !== 1'b1) begin errors++; $display("FAIL ld_after_idle got gnt=%0b rd=%0b want 1/1", ld_gnt, mem_rd); end
        tick();
        @(negedge clk);
        checks++; if (ld_rvalid !== 1'b1 || ld_rdata !== 8'hA3 || cpu_rdata !== 8'h00) begin errors++; $display("FAIL ld_rd_return got v=%0b d=%0h cpu_d=%0h want 1/a3/00", ld_rvalid, ld_rdata, cpu_rdata); end
        tick();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1; cpu_req = 1'b0; ld_req = 1'b0;
        tick();
        rst = 1'b0; cpu_req = 1'b1; ld_req = 1'b1;
        repeat (40) tick();
        @(negedge clk);
        checks++; if (conflict_cnt !== 16'd39) begin errors++; $display("FAIL stats_conflict got %0d want 39", conflict_cnt); end
        checks++; if (forced_cnt !== 8'd4) begin errors++; $display("FAIL stats_forced got %0d want 4", forced_cnt); end
        cpu_req = 1'b0; ld_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_read_switch_and_reset();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
